// File: rtl/noc_pkg.sv
// Shared NoC constants: output port indices, default flit geometry and a
// constant-evaluable clog2 used to size FIFO pointers.
package noc_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N_OUT = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO for one demux output; head entry is driven straight from
// registered storage so out_data never sees the input flit in the same cycle.
module demux_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/flit_demux_buf.sv
// 1-to-N_OUT flit demux with unicast/broadcast routing into per-output FIFOs;
// flits addressed to a non-existent port are sunk and counted.
module flit_demux_buf
  import noc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_OUT = DEFAULT_N_OUT,
  parameter int DEPTH = 2,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic               in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] push;
  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] empty;
  logic             sel_legal;
  logic             sel_full;
  logic             accept;
  logic             drop;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_port
      assign sel_hit[gi] = (in_sel == SEL_W'(gi));
      assign push[gi]    = accept & (in_bcast | sel_hit[gi]);

      demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push[gi]),
        .din   (in_data),
        .pop   (out_ready[gi]),
        .dout  (out_data[gi*WIDTH +: WIDTH]),
        .full  (full[gi]),
        .empty (empty[gi])
      );

      assign out_valid[gi] = ~empty[gi];
    end
  endgenerate

  // Full flags only: a same-cycle pop never frees room, keeping this path short.
  assign sel_legal = |sel_hit;
  assign sel_full  = |(full & sel_hit);

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)       in_ready = ~|full;
    else if (sel_legal) in_ready = ~sel_full;
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_legal;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_flit_demux_buf.sv
// Self-checking bench for flit_demux_buf: directed vector table, hand-written
// corner sequences and random traffic against a per-port queue model.
module tb_flit_demux_buf;
  import noc_pkg::*;

  localparam int W = 8;
  localparam int NO = 5;
  localparam int DP = 2;
  localparam int SW = 3;
  localparam int CW = 8;

  logic            clk;
  logic            reset;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic [SW-1:0]   in_sel;
  logic            in_bcast;
  logic            in_ready;
  logic [NO*W-1:0] out_data;
  logic [NO-1:0]   out_valid;
  logic [NO-1:0]   out_ready;
  logic [CW-1:0]   err_cnt;

  flit_demux_buf #(
    .WIDTH (W), .N_OUT (NO), .DEPTH (DP), .SEL_W (SW), .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: one queue per output plus a saturating drop counter.
  logic [W-1:0] mq [NO][$];
  int           merr = 0;

  logic            obs_rdy;
  logic [NO-1:0]   obs_vld;
  logic [NO*W-1:0] obs_data;
  logic [CW-1:0]   obs_err;

  typedef struct {
    logic          vld;
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          bc;
    logic [NO-1:0] rdy;
    logic          exp_rdy;
    logic [NO-1:0] exp_vld;
    logic [NO*W-1:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NO; k++) mq[k].delete();
    merr = 0;
  endtask

  // Called just after a rising edge: drive, sample mid-cycle, check, advance.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                     input logic b, input logic [NO-1:0] r);
    logic          exp_rdy;
    logic [NO-1:0] exp_vld;
    logic          acc;
    in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
    #4;
    obs_rdy = in_ready; obs_vld = out_valid; obs_data = out_data; obs_err = err_cnt;

    exp_rdy = 1'b1;
    if (b) begin
      for (int k = 0; k < NO; k++) if (mq[k].size() >= DP) exp_rdy = 1'b0;
    end else if (int'(s) < NO) begin
      exp_rdy = (mq[int'(s)].size() < DP);
    end
    for (int k = 0; k < NO; k++) exp_vld[k] = (mq[k].size() > 0);

    chk("in_ready", 64'(obs_rdy), 64'(exp_rdy));
    chk("out_valid", 64'(obs_vld), 64'(exp_vld));
    for (int k = 0; k < NO; k++)
      if (mq[k].size() > 0) chk("out_data", 64'(obs_data[k*W +: W]), 64'(mq[k][0]));
    chk("err_cnt", 64'(obs_err), 64'(merr));

    acc = v & exp_rdy;
    for (int k = 0; k < NO; k++)
      if (mq[k].size() > 0 && r[k]) void'(mq[k].pop_front());
    if (acc) begin
      if (b) for (int k = 0; k < NO; k++) mq[k].push_back(d);
      else if (int'(s) < NO) mq[int'(s)].push_back(d);
      else if (merr < (1 << CW) - 1) merr++;
      $display("txn t=%0t sel=%0d bcast=%0b data=%02h", $time, s, b, d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b00000, 40'h0};
    tbl[1]  = '{1'b1, 8'hA1, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b00000, 40'h0};
    tbl[2]  = '{1'b1, 8'hA1, 3'd1, 1'b0, 5'h1f, 1'b1, 5'b00001, 40'h00000000A1};
    tbl[3]  = '{1'b1, 8'hA1, 3'd2, 1'b0, 5'h1f, 1'b1, 5'b00010, 40'h000000A100};
    tbl[4]  = '{1'b1, 8'hA1, 3'd3, 1'b0, 5'h1f, 1'b1, 5'b00100, 40'h0000A10000};
    tbl[5]  = '{1'b1, 8'hA1, 3'd4, 1'b0, 5'h1f, 1'b1, 5'b01000, 40'h00A1000000};
    tbl[6]  = '{1'b0, 8'h00, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b10000, 40'hA100000000};
    tbl[7]  = '{1'b0, 8'h00, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b00000, 40'h0};
    tbl[8]  = '{1'b1, 8'h11, 3'd2, 1'b0, 5'h1b, 1'b1, 5'b00000, 40'h0};
    tbl[9]  = '{1'b1, 8'h22, 3'd2, 1'b0, 5'h1b, 1'b1, 5'b00100, 40'h0000110000};
    tbl[10] = '{1'b1, 8'h33, 3'd2, 1'b0, 5'h1b, 1'b0, 5'b00100, 40'h0000110000};
    tbl[11] = '{1'b1, 8'h44, 3'd3, 1'b0, 5'h1b, 1'b1, 5'b00100, 40'h0000110000};
    tbl[12] = '{1'b1, 8'h33, 3'd2, 1'b0, 5'h1f, 1'b0, 5'b01100, 40'h0044110000};
    tbl[13] = '{1'b1, 8'h33, 3'd2, 1'b0, 5'h1f, 1'b1, 5'b00100, 40'h0000220000};
    tbl[14] = '{1'b0, 8'h00, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b00100, 40'h0000330000};
    tbl[15] = '{1'b0, 8'h00, 3'd0, 1'b0, 5'h1f, 1'b1, 5'b00000, 40'h0};

    in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (5) cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    chk("reset_out_valid", 64'(obs_vld), 64'h0);
    chk("reset_in_ready", 64'(obs_rdy), 64'h1);
    chk("reset_err_cnt", 64'(obs_err), 64'h0);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].vld, tbl[i].data, tbl[i].sel, tbl[i].bc, tbl[i].rdy);
      chk("tbl_in_ready", 64'(obs_rdy), 64'(tbl[i].exp_rdy));
      chk("tbl_out_valid", 64'(obs_vld), 64'(tbl[i].exp_vld));
      for (int k = 0; k < NO; k++)
        if (tbl[i].exp_vld[k])
          chk("tbl_out_data", 64'(obs_data[k*W +: W]), 64'(tbl[i].exp_data[k*W +: W]));
    end

    // Broadcast blocked by a full FIFO[4], then released by draining it.
    cyc(1'b1, 8'h01, 3'(PORT_W), 1'b0, 5'h00);
    cyc(1'b1, 8'h02, 3'(PORT_W), 1'b0, 5'h00);
    cyc(1'b1, 8'h5A, 3'(PORT_LOCAL), 1'b1, 5'h00);
    chk("bcast_blocked_rdy", 64'(obs_rdy), 64'h0);
    cyc(1'b1, 8'h5A, 3'(PORT_LOCAL), 1'b1, 5'h00);
    chk("bcast_no_change", 64'(obs_vld), 64'h10);
    cyc(1'b1, 8'h5A, 3'(PORT_LOCAL), 1'b1, 5'h10);
    chk("bcast_full_pop_rdy", 64'(obs_rdy), 64'h0);
    cyc(1'b1, 8'h5A, 3'(PORT_LOCAL), 1'b1, 5'h10);
    chk("bcast_accept_rdy", 64'(obs_rdy), 64'h1);
    chk("bcast_second_head", 64'(obs_data[4*W +: W]), 64'h02);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h00);
    chk("bcast_all_valid", 64'(obs_vld), 64'h1f);
    for (int k = 0; k < NO; k++) chk("bcast_data", 64'(obs_data[k*W +: W]), 64'h5A);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    chk("bcast_drained", 64'(obs_vld), 64'h0);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 7) == 0), 5'($urandom));

    repeat (260) cyc(1'b1, 8'($urandom), 3'd7, 1'b0, 5'h1f);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    chk("illegal_err_sat", 64'(obs_err), 64'hFF);
    chk("illegal_no_valid", 64'(obs_vld), 64'h0);

    // Asynchronous reset mid-cycle with FIFO[1] full and a flit in flight.
    cyc(1'b1, 8'hC1, 3'(PORT_N), 1'b0, 5'h00);
    cyc(1'b1, 8'hC2, 3'(PORT_N), 1'b0, 5'h00);
    in_valid = 1'b1; in_data = 8'hEE; in_sel = 3'(PORT_E); in_bcast = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_err", 64'(err_cnt), 64'h0);
    chk("async_rst_data", 64'(out_data), 64'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    cyc(1'b1, 8'h77, 3'(PORT_N), 1'b0, 5'h1f);
    chk("post_rst_empty", 64'(obs_vld), 64'h0);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    chk("post_rst_valid", 64'(obs_vld), 64'h02);
    chk("post_rst_data", 64'(obs_data[1*W +: W]), 64'h77);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 5'h1f);
    chk("post_rst_drained", 64'(obs_vld), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
